console_uart_tx: RTL and testbench

//  Bus-side console transmitter: snoops TileLink-A writes to the console address window.

---
 rtl/console_uart_tx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_console_uart_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_uart_tx.sv
// Console transmitter: snoops TileLink-A PutPartialData writes to a console window,
// queues the low byte and shifts it out as 8N1 serial. Optional CR-before-LF insertion
// is enabled by defining CONSOLE_UART_CRLF_EN.

package console_uart_tx_pkg;

    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_D_ACCESS_ACK  = 3'd0;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [31:0] a_data;
    } tilelink_a_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [7:0]  d_source;
        logic [31:0] d_data;
    } tilelink_d_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// Handshake: a write transfers on a rising clock edge where it hits the window and
// tla_ready is high; the AccessAck is a single-cycle d_valid pulse on the next cycle.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter logic [31:0] addr_mask  = 32'hF000_0000,
    parameter logic [31:0] addr_tag   = 32'h0000_0000,
    parameter int unsigned clk_div    = 868,
    parameter int unsigned fifo_depth = 16
) (
    input  logic                        clock,
    input  logic                        tick_reset_n,
    input  tilelink_a_t                 tick_tla,
    output logic                        tla_ready,
    output tilelink_d_t                 tick_tld,
    output logic                        txd,
    output logic                        tx_busy,
    output logic [$clog2(fifo_depth):0] fifo_count,
    output tx_state_e                   dbg_state
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      BAUD_RELOAD = 16'(clk_div - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(fifo_depth);

    logic [7:0]       mem_q [fifo_depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;

    logic        d_valid_q, d_valid_d;
    logic [7:0]  d_source_q, d_source_d;

`ifdef CONSOLE_UART_CRLF_EN
    logic        crlf_pending_q, crlf_pending_d;
`endif

    logic        hit;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        load;
    logic [7:0]  push_byte;
    logic [7:0]  head_byte;
    logic        unused_a_data;

    assign hit = tick_tla.a_valid
              && ((tick_tla.a_address & addr_mask) == addr_tag)
              && (tick_tla.a_opcode == TL_A_PUT_PARTIAL);

    // Ready comes only from the registered count, so a pop cannot open a slot early.
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign push      = hit && !full;
    assign push_byte = (tick_tla.a_data[7:0] == 8'h00) ? 8'h3F : tick_tla.a_data[7:0];
    assign head_byte = mem_q[rd_ptr_q];

    assign unused_a_data = ^tick_tla.a_data[31:8];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        d_valid_d  = push;
        d_source_d = push ? tick_tla.a_source : d_source_q;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        load    = 1'b0;
        pop     = 1'b0;
`ifdef CONSOLE_UART_CRLF_EN
        crlf_pending_d = crlf_pending_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    state_d = ST_DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Starting a frame from IDLE or straight out of STOP (no idle gap).
        if (load) begin
            state_d = ST_START;
            baud_d  = BAUD_RELOAD;
            bit_d   = 3'd0;
`ifdef CONSOLE_UART_CRLF_EN
            // A LF at the head is first answered with a CR while the LF stays queued.
            if ((head_byte == 8'h0A) && !crlf_pending_q) begin
                shift_d        = 8'h0D;
                crlf_pending_d = 1'b1;
            end else begin
                shift_d        = head_byte;
                pop            = 1'b1;
                crlf_pending_d = 1'b0;
            end
`else
            shift_d = head_byte;
            pop     = 1'b1;
`endif
        end
    end

    // Line level follows the current state; registering it makes the start bit land
    // two cycles after the accepting edge when the queue was empty.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!tick_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            d_valid_q  <= 1'b0;
            d_source_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            d_valid_q  <= d_valid_d;
            d_source_q <= d_source_d;
        end
    end

`ifdef CONSOLE_UART_CRLF_EN
    always_ff @(posedge clock) begin
        if (!tick_reset_n) begin
            crlf_pending_q <= 1'b0;
        end else begin
            crlf_pending_q <= crlf_pending_d;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    assign tla_ready  = !full;
    assign txd        = txd_q;
    assign tx_busy    = (state_q != ST_IDLE) || !empty;
    assign fifo_count = count_q;
    assign dbg_state  = state_q;

    assign tick_tld.d_valid  = d_valid_q;
    assign tick_tld.d_opcode = TL_D_ACCESS_ACK;
    assign tick_tld.d_source = d_source_q;
    assign tick_tld.d_data   = 32'h0000_0000;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx with clk_div=4 and fifo_depth=4; a line monitor decodes
// 8N1 frames into rx_q, scored against bytes expected from accepted writes.
module tb_console_uart_tx;
    import console_uart_tx_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic        clock = 1'b0;
    logic        tick_reset_n;
    tilelink_a_t tla;
    logic        tla_ready;
    tilelink_d_t tld;
    logic        txd;
    logic        tx_busy;
    logic [2:0]  fifo_count;
    tx_state_e   dbg_state;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         rx_bad = 0;
    int         cyc    = 0;
    int         d_cnt  = 0;
    logic [7:0] last_d_source = 8'h00;

    console_uart_tx #(
        .addr_mask (32'hF000_0000),
        .addr_tag  (32'h0000_0000),
        .clk_div   (CLK_DIV),
        .fifo_depth(DEPTH)
    ) dut (
        .clock       (clock),
        .tick_reset_n(tick_reset_n),
        .tick_tla    (tla),
        .tla_ready   (tla_ready),
        .tick_tld    (tld),
        .txd         (txd),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- line monitor ----------------
    logic       mon_in_frame = 1'b0;
    int         mon_ph       = 0;
    int         mon_start    = 0;
    logic [7:0] mon_sh       = 8'h00;

    always @(negedge clock) begin
        if (tick_reset_n !== 1'b1) begin
            mon_in_frame = 1'b0;
        end else if (!mon_in_frame) begin
            if (txd === 1'b0) begin
                mon_in_frame = 1'b1;
                mon_ph       = 0;
                mon_start    = cyc;
            end
        end else begin
            mon_ph = mon_ph + 1;
            if ((mon_ph % CLK_DIV) == CLK_DIV / 2) begin
                if (mon_ph / CLK_DIV == 0) begin
                    if (txd !== 1'b0) rx_bad = rx_bad + 1;
                end else if (mon_ph / CLK_DIV <= 8) begin
                    mon_sh[mon_ph / CLK_DIV - 1] = txd;
                end else begin
                    if (txd !== 1'b1) rx_bad = rx_bad + 1;
                    rx_q.push_back(mon_sh);
                    rx_start_q.push_back(mon_start);
                end
            end
            if (mon_ph == FRAME - 1) mon_in_frame = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (tick_reset_n === 1'b1 && tld.d_valid === 1'b1) begin
            d_cnt         = d_cnt + 1;
            last_d_source = tld.d_source;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        tla = '0;
    endtask

    task automatic drive_put(input logic [31:0] addr, input logic [7:0] data,
                             input logic [2:0] op, input logic [7:0] src);
        tla.a_valid   = 1'b1;
        tla.a_opcode  = op;
        tla.a_source  = src;
        tla.a_address = addr;
        tla.a_data    = {24'hA5A5A5, data};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick_reset_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd got=%b exp=1", txd); end
        tests++; if (tla_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", tla_ready); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        tests++; if (tld.d_valid !== 1'b0) begin fails++; $display("FAIL reset_dvalid got=%b exp=0", tld.d_valid); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        @(posedge clock); #1;
        tick_reset_n = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_single();
        logic [9:0] seq;
        seq = 10'b1010000010;  // line levels for 'A', index 0 first
        @(posedge clock); #1;
        drive_put(32'h0000_0000, 8'h41, TL_A_PUT_PARTIAL, 8'h05);
        @(posedge clock);
        exp_q.push_back(8'h41);
        #1 drive_idle();
        @(negedge clock);
        tests++; if (tld.d_valid !== 1'b1) begin fails++; $display("FAIL single_dvalid got=%b exp=1", tld.d_valid); end
        tests++; if (tld.d_opcode !== TL_D_ACCESS_ACK) begin fails++; $display("FAIL single_dopcode got=%0d exp=%0d", tld.d_opcode, TL_D_ACCESS_ACK); end
        tests++; if (tld.d_source !== 8'h05) begin fails++; $display("FAIL single_dsource got=%h exp=05", tld.d_source); end
        tests++; if (tld.d_data !== 32'h0) begin fails++; $display("FAIL single_ddata got=%h exp=0", tld.d_data); end
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL single_txd_early1 got=%b exp=1", txd); end
        tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", tx_busy); end
        @(posedge clock);
        @(negedge clock);
        tests++; if (tld.d_valid !== 1'b0) begin fails++; $display("FAIL single_dpulse_len got=%b exp=0", tld.d_valid); end
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL single_txd_early2 got=%b exp=1", txd); end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CLK_DIV; j++) begin
                @(posedge clock);
                @(negedge clock);
                tests++;
                if (txd !== seq[i]) begin
                    fails++;
                    $display("FAIL single_txd bit=%0d cyc=%0d got=%b exp=%b", i, j, txd, seq[i]);
                end
            end
        end
        for (int i = 0; i < 20 && rx_q.size() < 1; i++) @(posedge clock);
        tests++;
        if (rx_q.size() < 1) begin
            fails++; $display("FAIL single_rx_timeout got=%0d frames exp=1", rx_q.size());
        end else begin
            logic [7:0] got, exp;
            got = rx_q.pop_front(); void'(rx_start_q.pop_front()); exp = exp_q.pop_front();
            tests++; if (got !== exp) begin fails++; $display("FAIL single_rx_byte got=%h exp=%h", got, exp); end
        end
        repeat (4) @(posedge clock);
        @(negedge clock);
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got=%b exp=0", tx_busy); end
    endtask

    task automatic test_miss();
        int   d0;
        int   bad_count;
        int   bad_txd;
        d0 = d_cnt; bad_count = 0; bad_txd = 0;
        @(posedge clock); #1;
        drive_put(32'h1000_0000, 8'h42, TL_A_PUT_PARTIAL, 8'h11);
        @(posedge clock); #1;
        drive_put(32'h0000_0000, 8'h43, 3'd4, 8'h12);
        @(posedge clock); #1;
        drive_put(32'hF000_0040, 8'h44, TL_A_PUT_PARTIAL, 8'h13);
        @(posedge clock); #1;
        drive_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (fifo_count !== 3'd0) bad_count++;
            if (txd !== 1'b1) bad_txd++;
        end
        tests++; if (d_cnt !== d0) begin fails++; $display("FAIL miss_dpulse got=%0d exp=%0d", d_cnt, d0); end
        tests++; if (bad_count !== 0) begin fails++; $display("FAIL miss_count nonzero_cycles=%0d exp=0", bad_count); end
        tests++; if (bad_txd !== 0) begin fails++; $display("FAIL miss_txd low_cycles=%0d exp=0", bad_txd); end
        tests++; if (rx_q.size() !== 0) begin fails++; $display("FAIL miss_rx got=%0d frames exp=0", rx_q.size()); end
    endtask

    task automatic test_fill();
        int         d0;
        logic [7:0] b;
        logic       rdy;
        logic [2:0] cnt_before;
        int         waited;
        d0 = d_cnt;
        @(posedge clock); #1;
        b = 8'($urandom_range(1, 9));
        drive_put(32'h0000_0100, b, TL_A_PUT_PARTIAL, 8'h20);
        @(posedge clock);
        exp_q.push_back(b);
        #1 drive_idle();
        repeat (3) @(posedge clock);
        #1;
        for (int idx = 1; idx <= 6; idx++) begin
            b = 8'($urandom_range(8'h20, 8'hFF));
            drive_put(32'($urandom_range(0, 32'h0FFF_FFFF)), b, TL_A_PUT_PARTIAL, 8'(8'h20 + idx));
            waited = 0;
            rdy = 1'b0;
            cnt_before = '0;
            while (!rdy && waited < 200) begin
                rdy = tla_ready;
                cnt_before = fifo_count;
                @(posedge clock);
                #1;
                waited++;
            end
            tests++;
            if (!rdy) begin
                fails++; $display("FAIL fill_accept_timeout write=%0d waited=%0d", idx, waited);
            end else begin
                exp_q.push_back(b);
            end
            if (idx == 4) begin
                tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL fill_full_count got=%0d exp=4", fifo_count); end
                tests++; if (tla_ready !== 1'b0) begin fails++; $display("FAIL fill_full_ready got=%b exp=0", tla_ready); end
            end
            if (idx == 5) begin
                tests++; if (cnt_before !== 3'(DEPTH - 1)) begin fails++; $display("FAIL fill_no_pop_push count_at_accept=%0d exp=%0d", cnt_before, DEPTH - 1); end
                tests++; if (waited < 2) begin fails++; $display("FAIL fill_stall waited=%0d exp>=2", waited); end
            end
        end
        drive_idle();
        for (int i = 0; i < 400 && rx_q.size() < 7; i++) @(posedge clock);
        tests++;
        if (rx_q.size() < 7) begin
            fails++; $display("FAIL fill_rx_timeout got=%0d frames exp=7", rx_q.size());
        end else begin
            int prev;
            prev = 0;
            for (int i = 0; i < 7; i++) begin
                logic [7:0] got, exp;
                int         st;
                got = rx_q.pop_front(); st = rx_start_q.pop_front(); exp = exp_q.pop_front();
                tests++; if (got !== exp) begin fails++; $display("FAIL fill_rx_byte idx=%0d got=%h exp=%h", i, got, exp); end
                if (i > 0) begin
                    tests++; if (st - prev !== FRAME) begin fails++; $display("FAIL fill_back_to_back idx=%0d spacing=%0d exp=%0d", i, st - prev, FRAME); end
                end
                prev = st;
            end
        end
        tests++; if (d_cnt - d0 !== 7) begin fails++; $display("FAIL fill_dpulses got=%0d exp=7", d_cnt - d0); end
        tests++; if (last_d_source !== 8'h26) begin fails++; $display("FAIL fill_last_source got=%h exp=26", last_d_source); end
        for (int i = 0; i < 100 && tx_busy; i++) @(posedge clock);
        repeat (3) @(posedge clock);
    endtask

    task automatic test_nul();
        int n;
        @(posedge clock); #1;
        drive_put(32'h0000_0004, 8'h00, TL_A_PUT_PARTIAL, 8'h30);
        @(posedge clock);
        exp_q.push_back(8'h3F);
        #1 drive_put(32'h0000_0004, 8'h0A, TL_A_PUT_PARTIAL, 8'h31);
        @(posedge clock);
`ifdef CONSOLE_UART_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        #1 drive_idle();
        n = exp_q.size();
        for (int i = 0; i < 300 && rx_q.size() < n; i++) @(posedge clock);
        tests++;
        if (rx_q.size() < n) begin
            fails++; $display("FAIL nul_rx_timeout got=%0d frames exp=%0d", rx_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                logic [7:0] got, exp;
                got = rx_q.pop_front(); void'(rx_start_q.pop_front()); exp = exp_q.pop_front();
                tests++; if (got !== exp) begin fails++; $display("FAIL nul_rx_byte idx=%0d got=%h exp=%h", i, got, exp); end
            end
        end
        repeat (20) @(posedge clock);
        tests++; if (rx_q.size() !== 0) begin fails++; $display("FAIL nul_extra_frames got=%0d exp=0", rx_q.size()); end
        tests++; if (rx_bad !== 0) begin fails++; $display("FAIL framing_errors got=%0d exp=0", rx_bad); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        int         rx0;
        int         low_cycles;
        b = 8'h55;
        @(posedge clock); #1;
        drive_put(32'h0000_0000, b, TL_A_PUT_PARTIAL, 8'h40);
        @(posedge clock); #1;
        drive_put(32'h0000_0000, 8'h66, TL_A_PUT_PARTIAL, 8'h41);
        @(posedge clock); #1;
        drive_idle();
        repeat (18) @(posedge clock);
        #1;
        tests++; if (dbg_state !== ST_DATA) begin fails++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, ST_DATA); end
        tests++; if (txd !== b[3]) begin fails++; $display("FAIL midrst_bit3 got=%b exp=%b", txd, b[3]); end
        rx0 = rx_q.size();
        tick_reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL midrst_txd got=%b exp=1", txd); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL midrst_count got=%0d exp=0", fifo_count); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", tx_busy); end
        tests++; if (tla_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", tla_ready); end
        @(posedge clock); #1;
        tick_reset_n = 1'b1;
        low_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (txd !== 1'b1) low_cycles++;
        end
        tests++; if (low_cycles !== 0) begin fails++; $display("FAIL midrst_no_frames low_cycles=%0d exp=0", low_cycles); end
        tests++; if (rx_q.size() !== rx0) begin fails++; $display("FAIL midrst_rx got=%0d exp=%0d", rx_q.size(), rx0); end
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL midrst_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tick_reset_n = 1'b0;
        drive_idle();
        test_reset();
        test_single();
        test_miss();
        test_fill();
        test_nul();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
